// File: rtl/jk_state_register.sv
// jk_state_register
// Sequential half of a 2-bit JK state machine. It holds q1/q0 as JK
// flip-flops and brings x1/x0 through a synchronizer. It presents the
// select word s = {q1,q0,x1_sync,x0_sync} to the external mux stage. On the
// next clock it takes back J/K and RG/RN, registers the outputs and counts
// state transitions in a saturating counter.
module jk_state_register #(
  parameter int unsigned SYNC_STAGES = 2,      // legal range 2..4
  parameter logic [1:0]  INIT_STATE  = 2'b00,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       x,
  input  logic             ce,
  input  logic             clr,
  input  logic             j1,
  input  logic             k1,
  input  logic             j0,
  input  logic             k0,
  input  logic             rg_in,
  input  logic             rn_in,
  output logic [3:0]       s,
  output logic [1:0]       q,
  output logic             rg,
  output logic             rn,
  output logic             state_chg,
  output logic [CNT_W-1:0] trans_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Synchronizer chain. Element 0 is the first stage and
  // element SYNC_STAGES-1 is the synchronized output.
  logic [SYNC_STAGES-1:0][1:0] sync_q, sync_d;

  logic [1:0]       q_q, q_d;
  logic             rg_q, rg_d;
  logic             rn_q, rn_d;
  logic             state_chg_q, state_chg_d;
  logic [CNT_W-1:0] trans_cnt_q, trans_cnt_d;

  // Next value of one JK flip-flop bit.
  function automatic logic jk_next(input logic cur, input logic j, input logic k);
    case ({j, k})
      2'b00:   return cur;
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      default: return ~cur;
    endcase
  endfunction

  // Synchronizer shift runs every cycle. It ignores ce and clr.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], x};
  end

  // Next state, registered mux results and transition bookkeeping.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves one unassigned and infers a latch.
    q_d         = q_q;
    rg_d        = rg_q;
    rn_d        = rn_q;
    state_chg_d = 1'b0;
    trans_cnt_d = trans_cnt_q;

    if (clr) begin
      // clr wins over ce and over any JK action on the same edge.
      q_d         = INIT_STATE;
      rg_d        = 1'b0;
      rn_d        = 1'b0;
      trans_cnt_d = '0;
    end else if (ce) begin
      q_d  = {jk_next(q_q[1], j1, k1), jk_next(q_q[0], j0, k0)};
      rg_d = rg_in;
      rn_d = rn_in;
      // A change in both bits on one edge counts as one transition.
      if (q_d != q_q) begin
        state_chg_d = 1'b1;
        if (trans_cnt_q != CNT_MAX) begin
          trans_cnt_d = trans_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // State and output registers. Reset is asynchronous and clears everything,
  // including a partially synchronized x value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      q_q         <= INIT_STATE;
      rg_q        <= 1'b0;
      rn_q        <= 1'b0;
      state_chg_q <= 1'b0;
      trans_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values, as real hardware does.
      sync_q      <= sync_d;
      q_q         <= q_d;
      rg_q        <= rg_d;
      rn_q        <= rn_d;
      state_chg_q <= state_chg_d;
      trans_cnt_q <= trans_cnt_d;
    end
  end

  // s is a plain concatenation of registers, with no logic in the path.
  assign s         = {q_q, sync_q[SYNC_STAGES-1]};
  assign q         = q_q;
  assign rg        = rg_q;
  assign rn        = rn_q;
  assign state_chg = state_chg_q;
  assign trans_cnt = trans_cnt_q;

endmodule

// File: tb/tb_jk_state_register.sv
// Directed testbench for jk_state_register. It uses SYNC_STAGES=2,
// INIT_STATE=00 and CNT_W=2, so counter saturation is reached in a few edges.
module tb_jk_state_register;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] x;
  logic       ce, clr, j1, k1, j0, k0, rg_in, rn_in;
  logic [3:0] s;
  logic [1:0] q;
  logic       rg, rn, state_chg;
  logic [1:0] trans_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  jk_state_register #(
    .SYNC_STAGES(2),
    .INIT_STATE (2'b00),
    .CNT_W      (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .x         (x),
    .ce        (ce),
    .clr       (clr),
    .j1        (j1),
    .k1        (k1),
    .j0        (j0),
    .k0        (k0),
    .rg_in     (rg_in),
    .rn_in     (rn_in),
    .s         (s),
    .q         (q),
    .rg        (rg),
    .rn        (rn),
    .state_chg (state_chg),
    .trans_cnt (trans_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then move off the edge before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_jk(input logic [3:0] v);
    {j1, k1, j0, k0} = v;
  endtask

  task automatic check_state(input string tag, input logic [1:0] eq,
                             input logic echg, input logic [1:0] ecnt);
    check({tag, ".q"},   32'(q),         32'(eq));
    check({tag, ".chg"}, 32'(state_chg), 32'(echg));
    check({tag, ".cnt"}, 32'(trans_cnt), 32'(ecnt));
  endtask

  initial begin
    // Vector table for the basic JK sequence: {jk}, expected q, chg, cnt.
    logic [3:0] jk_vec [4] = '{4'b1010, 4'b0011, 4'b1101, 4'b0100};
    logic [1:0] q_vec  [4] = '{2'b11,   2'b10,   2'b00,   2'b00};
    logic       chg_vec[4] = '{1'b1,    1'b1,    1'b1,    1'b0};
    logic [1:0] cnt_vec[4] = '{2'd1,    2'd2,    2'd3,    2'd3};
    logic [1:0] sat_cnt[5] = '{2'd1,    2'd2,    2'd3,    2'd3, 2'd3};

    rst_n = 1'b1; x = 2'b00; ce = 1'b0; clr = 1'b0;
    set_jk(4'b0000); rg_in = 1'b0; rn_in = 1'b0;

    // Reset is asynchronous, so values appear with no clock edge.
    #1 rst_n = 1'b0;
    #1;
    check("rst.s", 32'(s), 32'h0);
    check("rst.rg", 32'(rg), 32'h0);
    check("rst.rn", 32'(rn), 32'h0);
    check_state("rst", 2'b00, 1'b0, 2'd0);
    x = 2'b11;
    #1 check("rst.s_xchg", 32'(s), 32'h0);
    tick();
    check("rst.s_edge", 32'(s), 32'h0);
    x = 2'b00;
    tick();
    rst_n = 1'b1;
    tick();
    check_state("rel_ce0", 2'b00, 1'b0, 2'd0);

    // Basic JK sequence.
    ce = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_jk(jk_vec[i]);
      tick();
      check_state($sformatf("jk%0d", i), q_vec[i], chg_vec[i], cnt_vec[i]);
    end

    // Saturation: clear, then toggle q0 five times.
    clr = 1'b1; tick(); clr = 1'b0;
    check_state("clr0", 2'b00, 1'b0, 2'd0);
    set_jk(4'b0011);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_state($sformatf("sat%0d", i), {1'b0, ~i[0]}, 1'b1, sat_cnt[i]);
    end

    // ce=0 holds everything even with toggle on both bits.
    ce = 1'b0; set_jk(4'b1111);
    tick();
    check_state("ce0_hold", 2'b01, 1'b0, 2'd3);

    // clr acts with ce=0.
    clr = 1'b1; tick(); clr = 1'b0;
    check_state("clr_ce0", 2'b00, 1'b0, 2'd0);

    // A change in both bits counts as one transition.
    ce = 1'b1; set_jk(4'b1000);
    tick();
    check_state("two_a", 2'b10, 1'b1, 2'd1);
    set_jk(4'b0110);
    tick();
    check_state("two_b", 2'b01, 1'b1, 2'd2);

    // clr beats a simultaneous set of q0.
    clr = 1'b1; set_jk(4'b0010);
    tick(); clr = 1'b0;
    check_state("clr_jk", 2'b00, 1'b0, 2'd0);

    // rg/rn update only on enabled edges.
    set_jk(4'b0000); rg_in = 1'b1; rn_in = 1'b1; ce = 1'b0;
    tick();
    check("rgrn_ce0.rg", 32'(rg), 32'h0);
    check("rgrn_ce0.rn", 32'(rn), 32'h0);
    ce = 1'b1;
    tick();
    check("rgrn_ce1.rg", 32'(rg), 32'h1);
    check("rgrn_ce1.rn", 32'(rn), 32'h1);
    rg_in = 1'b0; ce = 1'b0;
    tick();
    check("rgrn_hold.rg", 32'(rg), 32'h1);
    ce = 1'b1;
    tick();
    check("rgrn_upd.rg", 32'(rg), 32'h0);
    check("rgrn_upd.rn", 32'(rn), 32'h1);

    // Synchronizer latency is two edges, with ce=1 and again with ce=0.
    x = 2'b11;
    tick();
    check("sync1.s", 32'(s), 32'h0);
    tick();
    check("sync2.s", 32'(s), 32'h3);
    ce = 1'b0; set_jk(4'b1111); x = 2'b01;
    tick();
    check("sync_ce0_1.s", 32'(s), 32'h3);
    tick();
    check("sync_ce0_2.s", 32'(s), 32'h1);

    // Reset asserted mid-cycle clears state before the next edge.
    ce = 1'b1; set_jk(4'b1010); rg_in = 1'b1; x = 2'b10;
    tick();
    check_state("pre_rst", 2'b11, 1'b1, 2'd1);
    check("pre_rst.rg", 32'(rg), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check_state("mid_rst", 2'b00, 1'b0, 2'd0);
    check("mid_rst.rg", 32'(rg), 32'h0);
    check("mid_rst.s", 32'(s), 32'h0);
    tick();
    rst_n = 1'b1; ce = 1'b0;
    // Only the first stage has seen x=10 since release, so s[1:0] is still 00.
    tick();
    check("post_rst.s", 32'(s), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
